// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, ECALL, RESUME} hz_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam logic [31:0] ECALL_INSTR = 32'h00000073;
  localparam int unsigned REG_X0      = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per GPR for in-flight destinations, with a same-cycle retirement bypass on reads.
module reg_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned REGW  = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_set,
  input  logic [REGW-1:0] i_set_idx,
  input  logic            i_clr,
  input  logic [REGW-1:0] i_clr_idx,
  input  logic [REGW-1:0] i_rd_a,
  input  logic [REGW-1:0] i_rd_b,
  output logic            o_busy_a,
  output logic            o_busy_b
);

  localparam logic [REGW-1:0] X0 = REGW'(REG_X0);

  logic [NREGS-1:0] r_sb;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_sb_eff;
  logic [NREGS-1:0] w_sb_d;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set && i_set_idx != X0) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr && i_clr_idx != X0) w_clr_mask[i_clr_idx] = 1'b1;
    w_sb_eff = r_sb & ~w_clr_mask;
    // A set and a clear of the same register in one cycle leaves it busy.
    w_sb_d   = w_sb_eff | w_set_mask;
  end

  assign o_busy_a = (i_rd_a != X0) & w_sb_eff[i_rd_a];
  assign o_busy_b = (i_rd_b != X0) & w_sb_eff[i_rd_b];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sb <= '0;
    else          r_sb <= w_sb_d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: RAW stalls via the scoreboard, branch squash, in-flight limit and
// ecall drain/handoff/resume sequencing.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned REGW         = 5,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_id_valid,
  input  logic [REGW-1:0] i_id_rs1,
  input  logic            i_id_rs1_used,
  input  logic [REGW-1:0] i_id_rs2,
  input  logic            i_id_rs2_used,
  input  logic [REGW-1:0] i_id_rd,
  input  logic            i_id_rd_wr,
  input  logic            i_id_is_ecall,
  input  logic            i_ex_branch_taken,
  input  logic            i_wb_valid,
  input  logic [REGW-1:0] i_wb_rd,
  input  logic            i_ecall_done,
  output logic            o_issue,
  output logic            o_id_stall,
  output logic            o_if_stall,
  output logic            o_id_flush,
  output logic            o_ecall_req,
  output logic            o_ecall_active,
  output logic [3:0]      o_inflight
);

  localparam logic [3:0] MaxInfl = 4'(MAX_INFLIGHT);

  hz_state_t  r_state, w_state_d;
  logic [3:0] r_inflight, w_inflight_d;
  logic       r_ecall_req, w_ecall_req_d;
  logic       r_ecall_active, w_ecall_active_d;

  logic w_busy1, w_busy2, w_hazard, w_full, w_dec;
  logic w_stall, w_issue, w_flush;

  reg_scoreboard #(
    .NREGS (NREGS),
    .REGW  (REGW)
  ) u_sb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_set     (w_issue & i_id_rd_wr),
    .i_set_idx (i_id_rd),
    .i_clr     (i_wb_valid),
    .i_clr_idx (i_wb_rd),
    .i_rd_a    (i_id_rs1),
    .i_rd_b    (i_id_rs2),
    .o_busy_a  (w_busy1),
    .o_busy_b  (w_busy2)
  );

  assign w_hazard = i_id_valid & ((i_id_rs1_used & w_busy1) | (i_id_rs2_used & w_busy2));
  assign w_full   = (r_inflight == MaxInfl) & ~i_wb_valid;

  always_comb begin
    w_flush          = i_ex_branch_taken;
    w_stall          = 1'b0;
    w_issue          = 1'b0;
    w_state_d        = r_state;
    w_ecall_req_d    = 1'b0;
    w_ecall_active_d = r_ecall_active;
    unique case (r_state)
      RUN: begin
        w_stall = ~w_flush & (w_hazard | w_full | (i_id_is_ecall & i_id_valid));
        w_issue = i_id_valid & ~w_stall & ~w_flush & ~i_id_is_ecall;
        if (i_id_valid && i_id_is_ecall && !i_ex_branch_taken) w_state_d = DRAIN;
      end
      DRAIN: begin
        w_stall = ~w_flush;
        if (i_ex_branch_taken) begin
          w_state_d = RUN;
        end else if (r_inflight == 4'd0) begin
          w_state_d        = ECALL;
          w_ecall_req_d    = 1'b1;
          w_ecall_active_d = 1'b1;
        end
      end
      ECALL: begin
        w_stall = ~w_flush;
        if (i_ecall_done) begin
          w_state_d        = RESUME;
          w_ecall_active_d = 1'b0;
        end
      end
      RESUME: begin
        // The ecall still sitting in decode is replaced by a NOP.
        w_flush   = 1'b1;
        w_state_d = RUN;
      end
      default: w_state_d = RUN;
    endcase
  end

  assign w_dec        = i_wb_valid & (r_inflight != 4'd0);
  assign w_inflight_d = r_inflight + {3'd0, w_issue} - {3'd0, w_dec};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= RUN;
      r_inflight     <= 4'd0;
      r_ecall_req    <= 1'b0;
      r_ecall_active <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_inflight     <= w_inflight_d;
      r_ecall_req    <= w_ecall_req_d;
      r_ecall_active <= w_ecall_active_d;
    end
  end

  assign o_issue        = w_issue;
  assign o_id_stall     = w_stall;
  assign o_if_stall     = w_stall;
  assign o_id_flush     = w_flush;
  assign o_ecall_req    = r_ecall_req;
  assign o_ecall_active = r_ecall_active;
  assign o_inflight     = r_inflight;

  a_wb_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_wb_valid && r_inflight == 4'd0))
    else $error("wb_valid with nothing in flight");

  a_branch_drained: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_ex_branch_taken && (r_state == ECALL || r_state == RESUME)))
    else $error("branch taken while pipe is drained for ecall");

endmodule
